// File: rtl/ex_stage_pipe_regs_pkg.sv
// rtl/ex_stage_pipe_regs_pkg.sv - shared widths and bundle layouts for the ID/EX and EX/MEM registers
// Purpose: defines the datapath widths and the packed stage bundles.
// Ports: none (package).
package ex_stage_pkg;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;

    // Control block (12 bits) + three data words + three register indices.
    typedef struct packed {
        logic              alu_src;
        logic [2:0]        alu_op;
        logic              mem_write;
        logic              mem_read;
        logic [3:0]        xfer_size;
        logic              mem2reg;
        logic              reg_write;
        logic [DATA_W-1:0] read_data_1;
        logic [DATA_W-1:0] read_data_2;
        logic [DATA_W-1:0] alu_const;
        logic [REG_W-1:0]  write_reg;
        logic [REG_W-1:0]  rn;
        logic [REG_W-1:0]  rm;
    } id_ex_t;

    typedef struct packed {
        logic              mem_write;
        logic              mem_read;
        logic [3:0]        xfer_size;
        logic              mem2reg;
        logic              reg_write;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] write_data;
        logic [REG_W-1:0]  write_reg;
    } ex_mem_t;

    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);

endpackage

// File: rtl/dff_en_n.sv
// rtl/dff_en_n.sv - WIDTH-bit register with synchronous active-high clear and load enable
// Purpose: generic pipeline register.
// Ports: clk - clock; reset - synchronous clear (priority over load);
//        wr_en - load enable; d - next value; q - registered value.
module dff_en_n #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (wr_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_stage_pipe_regs.sv
// rtl/ex_stage_pipe_regs.sv - ID/EX and EX/MEM pipeline registers around the execute stage
// Purpose: two independent one-cycle register stages that capture every cycle;
//          reset clears both bundles to all-zero, which is a NOP in each stage.
// Ports: clk - clock; reset - synchronous active-high clear;
//        id_bundle / ex_bundle - packed id_ex_t in / registered out;
//        ex_result_bundle / mem_bundle - packed ex_mem_t in / registered out.
module ex_stage_pipe_regs
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = ex_stage_pkg::DATA_W,
    parameter int REG_W  = ex_stage_pkg::REG_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [12+3*DATA_W+3*REG_W-1:0]   id_bundle,
    output logic [12+3*DATA_W+3*REG_W-1:0]   ex_bundle,
    input  logic [8+2*DATA_W+REG_W-1:0]      ex_result_bundle,
    output logic [8+2*DATA_W+REG_W-1:0]      mem_bundle
);

    localparam int ID_W  = 12 + 3*DATA_W + 3*REG_W;
    localparam int MEM_W = 8 + 2*DATA_W + REG_W;

    // No stall or flush: bubbles are made upstream by zeroing control fields.
    dff_en_n #(.WIDTH(ID_W)) u_id_ex (
        .clk   (clk),
        .reset (reset),
        .wr_en (1'b1),
        .d     (id_bundle),
        .q     (ex_bundle)
    );

    dff_en_n #(.WIDTH(MEM_W)) u_ex_mem (
        .clk   (clk),
        .reset (reset),
        .wr_en (1'b1),
        .d     (ex_result_bundle),
        .q     (mem_bundle)
    );

endmodule

// File: tb/tb_ex_stage_pipe_regs.sv
// tb/tb_ex_stage_pipe_regs.sv - self-checking bench for ex_stage_pipe_regs and dff_en_n
module tb_ex_stage_pipe_regs;
    import ex_stage_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic [ID_EX_W-1:0]  id_bundle;
    logic [ID_EX_W-1:0]  ex_bundle;
    logic [EX_MEM_W-1:0] ex_result_bundle;
    logic [EX_MEM_W-1:0] mem_bundle;

    logic       r8_reset;
    logic       r8_wr_en;
    logic [7:0] r8_d;
    logic [7:0] r8_q;

    int total = 0;
    int bad   = 0;

    logic [ID_EX_W-1:0]  exp_ex;
    logic [EX_MEM_W-1:0] exp_mem;

    always #5 clk = ~clk;

    ex_stage_pipe_regs dut (
        .clk              (clk),
        .reset            (reset),
        .id_bundle        (id_bundle),
        .ex_bundle        (ex_bundle),
        .ex_result_bundle (ex_result_bundle),
        .mem_bundle       (mem_bundle)
    );

    dff_en_n #(.WIDTH(8)) u_r8 (
        .clk   (clk),
        .reset (r8_reset),
        .wr_en (r8_wr_en),
        .d     (r8_d),
        .q     (r8_q)
    );

    task automatic check(input string tag, input logic [ID_EX_W-1:0] obs, input logic [ID_EX_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; reference model: each stage holds what its input
    // was at the edge, or zero when reset was high.
    task automatic tick();
        @(posedge clk);
        #1;
        exp_ex  = reset ? '0 : id_bundle;
        exp_mem = reset ? '0 : ex_result_bundle;
    endtask

    function automatic logic [ID_EX_W-1:0] rand_id();
        logic [ID_EX_W-1:0] v = '0;
        for (int k = 0; k < 7; k++) v = (v << 32) | ID_EX_W'($urandom);
        return v;
    endfunction

    function automatic logic [EX_MEM_W-1:0] rand_mem();
        logic [EX_MEM_W-1:0] v = '0;
        for (int k = 0; k < 5; k++) v = (v << 32) | EX_MEM_W'($urandom);
        return v;
    endfunction

    initial begin
        id_ex_t  ids;
        ex_mem_t ems;
        ex_mem_t got;

        r8_reset = 1'b0; r8_wr_en = 1'b0; r8_d = '0;

        // Reset with all inputs at ones.
        reset = 1'b1;
        id_bundle = '1;
        ex_result_bundle = '1;
        @(negedge clk);
        tick();
        check("reset_ex", ex_bundle, '0);
        check("reset_mem", {78'b0, mem_bundle}, '0);

        // Capture test: visible one edge later, not before.
        reset = 1'b0;
        ids = '0;
        ids.read_data_1 = 64'h0123456789ABCDEF;
        ids.alu_op = 3'b010;
        ids.rn = 5'd3;
        ids.rm = 5'd31;
        id_bundle = ids;
        ex_result_bundle = '0;
        #1;
        check("capture_before_edge", ex_bundle, '0);
        tick();
        check("capture_ex", ex_bundle, ids);
        check("capture_rd1", ID_EX_W'(ex_bundle[3*REG_W+2*DATA_W +: DATA_W]), ID_EX_W'(64'h0123456789ABCDEF));
        check("capture_rn_rm", ID_EX_W'(ex_bundle[2*REG_W-1:0]), ID_EX_W'({5'd3, 5'd31}));

        // Stream test: alu_result 1,2,3 on successive cycles.
        for (int i = 1; i <= 3; i++) begin
            ems = '0;
            ems.alu_result = 64'(i);
            ex_result_bundle = ems;
            tick();
            got = mem_bundle;
            check($sformatf("stream_%0d", i), ID_EX_W'(got.alu_result), ID_EX_W'(i));
        end
        ex_result_bundle = '0;
        tick();
        check("stream_drain", {78'b0, mem_bundle}, '0);

        // Mid-stream reset.
        ems = '0;
        ems.reg_write = 1'b1;
        ems.write_reg = 5'd9;
        ems.alu_result = 64'hDEAD_BEEF;
        ex_result_bundle = ems;
        tick();
        check("pre_reset_mem", {78'b0, mem_bundle}, {78'b0, exp_mem});
        reset = 1'b1;
        tick();
        got = mem_bundle;
        check("midreset_reg_write", ID_EX_W'(got.reg_write), '0);
        check("midreset_write_reg", ID_EX_W'(got.write_reg), '0);
        check("midreset_all", {78'b0, mem_bundle}, '0);
        reset = 1'b0;
        tick();
        check("resume_mem", {78'b0, mem_bundle}, {78'b0, EX_MEM_W'(ems)});

        // dff_en_n at WIDTH=8: load, hold, clear.
        r8_d = 8'hA5; r8_wr_en = 1'b1;
        tick();
        check("r8_load", ID_EX_W'(r8_q), ID_EX_W'(8'hA5));
        r8_d = 8'h3C; r8_wr_en = 1'b0;
        tick();
        check("r8_hold", ID_EX_W'(r8_q), ID_EX_W'(8'hA5));
        r8_reset = 1'b1;
        tick();
        check("r8_reset", ID_EX_W'(r8_q), '0);
        r8_reset = 1'b0;

        // Walking one across both bundles.
        for (int i = 0; i < ID_EX_W; i++) begin
            id_bundle = ID_EX_W'(1) << i;
            ex_result_bundle = (i < EX_MEM_W) ? (EX_MEM_W'(1) << i) : '0;
            tick();
            check($sformatf("walk_ex_%0d", i), ex_bundle, ID_EX_W'(1) << i);
            if (i < EX_MEM_W)
                check($sformatf("walk_mem_%0d", i), {78'b0, mem_bundle}, ID_EX_W'(1) << i);
        end

        // Random traffic with occasional resets.
        for (int n = 0; n < 300; n++) begin
            reset = ($urandom_range(0, 15) == 0);
            id_bundle = rand_id();
            ex_result_bundle = (n % 7 == 0) ? '0 : rand_mem();
            tick();
            check($sformatf("rand_ex_%0d", n), ex_bundle, exp_ex);
            check($sformatf("rand_mem_%0d", n), {78'b0, mem_bundle}, {78'b0, exp_mem});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
